// File: rtl/pip_mem_wb_hs.sv
// MEM/WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// It also provides writeback forwarding lookup, flush and a saturating stall counter.
module pip_mem_wb_hs #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RAD_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rd,
    input  logic [RAD_W-1:0] rs1_ad,
    input  logic [RAD_W-1:0] rs2_ad,
    input  logic [RAD_W-1:0] rd_ad,
    input  logic             rdEn,
    input  logic             DMread,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  rd_p,
    output logic [RAD_W-1:0] rs1_ad_p,
    output logic [RAD_W-1:0] rs2_ad_p,
    output logic [RAD_W-1:0] rd_ad_p,
    output logic             rdEn_p,
    output logic             DMread_p,
    input  logic [RAD_W-1:0] qry_rs1_ad,
    input  logic [RAD_W-1:0] qry_rs2_ad,
    output logic             fwd_rs1_hit,
    output logic             fwd_rs2_hit,
    output logic [XLEN-1:0]  fwd_rs1_data,
    output logic [XLEN-1:0]  fwd_rs2_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]  rd;
        logic [RAD_W-1:0] rs1_ad;
        logic [RAD_W-1:0] rs2_ad;
        logic [RAD_W-1:0] rd_ad;
        logic             rdEn;
        logic             DMread;
    } entry_t;

    entry_t           in_e;
    entry_t           out_q, out_d;
    entry_t           skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             in_fire;
    logic             out_fire;

    assign in_e = '{rd: rd, rs1_ad: rs1_ad, rs2_ad: rs2_ad, rd_ad: rd_ad,
                    rdEn: rdEn, DMread: DMread};

    // in_ready depends only on state, so out_ready never reaches it combinationally
    assign in_ready = ~skid_valid_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_d        = '0;
            skid_d       = '0;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = in_e;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = in_e;
            skid_valid_d = 1'b1;
        end
    end

    // Saturating stall counter; flush leaves it alone
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rd_p      = out_q.rd;
    assign rs1_ad_p  = out_q.rs1_ad;
    assign rs2_ad_p  = out_q.rs2_ad;
    assign rd_ad_p   = out_q.rd_ad;
    assign rdEn_p    = out_q.rdEn & out_valid_q;
    assign DMread_p  = out_q.DMread & out_valid_q;
    assign stall_cnt = stall_cnt_q;

    function automatic logic cand(input logic v, input entry_t e, input logic [RAD_W-1:0] q);
        return v & e.rdEn & (e.rd_ad != '0) & (e.rd_ad == q);
    endfunction

    logic s1_skid, s1_out, s2_skid, s2_out;

    // Skid holds the younger entry, so it takes precedence over the output entry
    always_comb begin
        s1_skid      = cand(skid_valid_q, skid_q, qry_rs1_ad);
        s1_out       = cand(out_valid_q, out_q, qry_rs1_ad);
        s2_skid      = cand(skid_valid_q, skid_q, qry_rs2_ad);
        s2_out       = cand(out_valid_q, out_q, qry_rs2_ad);
        fwd_rs1_hit  = s1_skid | s1_out;
        fwd_rs2_hit  = s2_skid | s2_out;
        fwd_rs1_data = s1_skid ? skid_q.rd : (s1_out ? out_q.rd : '0);
        fwd_rs2_data = s2_skid ? skid_q.rd : (s2_out ? out_q.rd : '0);
    end

endmodule

// File: tb/tb_pip_mem_wb_hs.sv
// Directed bench for pip_mem_wb_hs: streaming, backpressure, flush, forwarding,
// counter saturation and reset priority.
module tb_pip_mem_wb_hs;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] rd;
    logic [4:0]  rs1_ad, rs2_ad, rd_ad, qry_rs1_ad, qry_rs2_ad;
    logic        rdEn, DMread;

    logic        in_ready, out_valid, rdEn_p, DMread_p, fwd_rs1_hit, fwd_rs2_hit;
    logic [31:0] rd_p, fwd_rs1_data, fwd_rs2_data;
    logic [4:0]  rs1_ad_p, rs2_ad_p, rd_ad_p;
    logic [15:0] stall_cnt;

    logic        s_rst, s_flush, s_in_valid, s_out_ready;
    logic        s_in_ready, s_out_valid, s_rdEn_p, s_DMread_p, s_h1, s_h2;
    logic [31:0] s_rd_p, s_d1, s_d2;
    logic [4:0]  s_rs1_ad_p, s_rs2_ad_p, s_rd_ad_p;
    logic [1:0]  s_stall_cnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pip_mem_wb_hs dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rd(rd), .rs1_ad(rs1_ad), .rs2_ad(rs2_ad), .rd_ad(rd_ad), .rdEn(rdEn),
        .DMread(DMread), .out_valid(out_valid), .out_ready(out_ready), .rd_p(rd_p),
        .rs1_ad_p(rs1_ad_p), .rs2_ad_p(rs2_ad_p), .rd_ad_p(rd_ad_p), .rdEn_p(rdEn_p),
        .DMread_p(DMread_p), .qry_rs1_ad(qry_rs1_ad), .qry_rs2_ad(qry_rs2_ad),
        .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
        .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data), .stall_cnt(stall_cnt)
    );

    pip_mem_wb_hs #(.XLEN(32), .RAD_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(s_rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .rd(rd), .rs1_ad(rs1_ad), .rs2_ad(rs2_ad), .rd_ad(rd_ad), .rdEn(rdEn),
        .DMread(DMread), .out_valid(s_out_valid), .out_ready(s_out_ready), .rd_p(s_rd_p),
        .rs1_ad_p(s_rs1_ad_p), .rs2_ad_p(s_rs2_ad_p), .rd_ad_p(s_rd_ad_p), .rdEn_p(s_rdEn_p),
        .DMread_p(s_DMread_p), .qry_rs1_ad(qry_rs1_ad), .qry_rs2_ad(qry_rs2_ad),
        .fwd_rs1_hit(s_h1), .fwd_rs2_hit(s_h2),
        .fwd_rs1_data(s_d1), .fwd_rs2_data(s_d2), .stall_cnt(s_stall_cnt)
    );

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] d, input logic [4:0] a,
                          input logic en, input logic ld);
        in_valid = v; rd = d; rd_ad = a; rdEn = en; DMread = ld;
        rs1_ad = a + 5'd1; rs2_ad = a + 5'd2;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); rst = 1'b0;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        vecs++; if (rd_p !== 32'h0) begin errs++; $display("FAIL reset_rd_p got %h exp 0", rd_p); end
        vecs++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_d;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'((i + 1) * 17);
            set_in(1'b1, exp_d, 5'(i + 1), 1'b1, 1'b0);
            step();
            vecs++; if (out_valid !== 1'b1 || rd_p !== exp_d || rd_ad_p !== 5'(i + 1)) begin
                errs++; $display("FAIL stream_%0d got v=%b rd=%h ad=%0d exp v=1 rd=%h ad=%0d",
                                 i, out_valid, rd_p, rd_ad_p, exp_d, i + 1);
            end
            vecs++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL stream_cnt_%0d got %0d exp 0", i, stall_cnt); end
        end
        in_valid = 1'b0;
        step();
        vecs++; if (out_valid !== 1'b0 || rdEn_p !== 1'b0) begin
            errs++; $display("FAIL stream_drain got v=%b rdEn_p=%b exp 0 0", out_valid, rdEn_p);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(1'b1, 32'hA, 5'd6, 1'b1, 1'b0); step();
        set_in(1'b1, 32'hB, 5'd7, 1'b1, 1'b0); step();
        in_valid = 1'b0;
        vecs++; if (in_ready !== 1'b0 || rd_p !== 32'hA) begin
            errs++; $display("FAIL bp_skid got in_ready=%b rd=%h exp 0 a", in_ready, rd_p);
        end
        step(); step();
        vecs++; if (stall_cnt !== 16'd3) begin errs++; $display("FAIL bp_cnt got %0d exp 3", stall_cnt); end
        out_ready = 1'b1; step();
        vecs++; if (out_valid !== 1'b1 || rd_p !== 32'hB || rd_ad_p !== 5'd7 || in_ready !== 1'b1) begin
            errs++; $display("FAIL bp_release got v=%b rd=%h ad=%0d rdy=%b exp 1 b 7 1", out_valid, rd_p, rd_ad_p, in_ready);
        end
        vecs++; if (stall_cnt !== 16'd3) begin errs++; $display("FAIL bp_cnt_hold got %0d exp 3", stall_cnt); end
        step();
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_in(1'b1, 32'h1, 5'd1, 1'b1, 1'b1); step();
        set_in(1'b1, 32'h2, 5'd2, 1'b1, 1'b0); step();
        set_in(1'b1, 32'hC, 5'd3, 1'b1, 1'b1); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        vecs++; if (out_valid !== 1'b0 || rd_p !== 32'h0 || rdEn_p !== 1'b0 || rd_ad_p !== 5'd0 || in_ready !== 1'b1) begin
            errs++; $display("FAIL flush_state got v=%b rd=%h en=%b ad=%0d rdy=%b exp 0 0 0 0 1",
                             out_valid, rd_p, rdEn_p, rd_ad_p, in_ready);
        end
        vecs++; if (stall_cnt !== 16'd5) begin errs++; $display("FAIL flush_cnt got %0d exp 5", stall_cnt); end
        out_ready = 1'b1; step();
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_drop got v=%b rd=%h exp v=0", out_valid, rd_p); end
    endtask

    task automatic test_forward();
        out_ready = 1'b0; qry_rs1_ad = 5'd5; qry_rs2_ad = 5'd3;
        set_in(1'b1, 32'h55, 5'd5, 1'b1, 1'b0); step();
        vecs++; if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 32'h55) begin
            errs++; $display("FAIL fwd_out got hit=%b d=%h exp 1 55", fwd_rs1_hit, fwd_rs1_data);
        end
        set_in(1'b1, 32'h66, 5'd5, 1'b1, 1'b0); step();
        in_valid = 1'b0;
        vecs++; if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 32'h66) begin
            errs++; $display("FAIL fwd_skid got hit=%b d=%h exp 1 66", fwd_rs1_hit, fwd_rs1_data);
        end
        vecs++; if (fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== 32'h0) begin
            errs++; $display("FAIL fwd_miss got hit=%b d=%h exp 0 0", fwd_rs2_hit, fwd_rs2_data);
        end
        flush = 1'b1; step(); flush = 1'b0;
        qry_rs2_ad = 5'd0;
        set_in(1'b1, 32'h77, 5'd0, 1'b1, 1'b0); step();
        in_valid = 1'b0;
        vecs++; if (fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== 32'h0) begin
            errs++; $display("FAIL fwd_x0 got hit=%b d=%h exp 0 0", fwd_rs2_hit, fwd_rs2_data);
        end
        flush = 1'b1; step(); flush = 1'b0;
        qry_rs1_ad = 5'd9;
        set_in(1'b1, 32'h88, 5'd9, 1'b0, 1'b1); step();
        in_valid = 1'b0;
        vecs++; if (fwd_rs1_hit !== 1'b0 || fwd_rs1_data !== 32'h0) begin
            errs++; $display("FAIL fwd_noen got hit=%b d=%h exp 0 0", fwd_rs1_hit, fwd_rs1_data);
        end
        vecs++; if (DMread_p !== 1'b1 || rs1_ad_p !== 5'd10 || rs2_ad_p !== 5'd11) begin
            errs++; $display("FAIL fwd_payload got ld=%b rs1=%0d rs2=%0d exp 1 10 11", DMread_p, rs1_ad_p, rs2_ad_p);
        end
        out_ready = 1'b1; step();
    endtask

    task automatic test_saturate();
        s_rst = 1'b1; step(); s_rst = 1'b0;
        s_out_ready = 1'b0;
        set_in(1'b0, 32'hDD, 5'd3, 1'b1, 1'b1);
        s_in_valid = 1'b1; step(); s_in_valid = 1'b0;
        step(); step();
        vecs++; if (s_stall_cnt !== 2'd2) begin errs++; $display("FAIL sat_mid got %0d exp 2", s_stall_cnt); end
        step(); step(); step();
        vecs++; if (s_stall_cnt !== 2'd3) begin errs++; $display("FAIL sat_cnt got %0d exp 3", s_stall_cnt); end
        s_rst = 1'b1; s_flush = 1'b1; s_in_valid = 1'b1; step();
        s_rst = 1'b0; s_flush = 1'b0; s_in_valid = 1'b0;
        vecs++; if (s_out_valid !== 1'b0 || s_rd_p !== 32'h0 || s_rd_ad_p !== 5'd0 || s_rdEn_p !== 1'b0 ||
                    s_DMread_p !== 1'b0 || s_stall_cnt !== 2'd0 || s_in_ready !== 1'b1) begin
            errs++; $display("FAIL rst_prio got v=%b rd=%h ad=%0d en=%b ld=%b cnt=%0d rdy=%b exp 0 0 0 0 0 0 1",
                             s_out_valid, s_rd_p, s_rd_ad_p, s_rdEn_p, s_DMread_p, s_stall_cnt, s_in_ready);
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1; qry_rs1_ad = 5'd0; qry_rs2_ad = 5'd0;
        set_in(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        s_rst = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_forward();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
